// File: rtl/sdram2fifo.sv
// sdram2fifo: burst-reads SDRAM into a FIFO and presents it as a first-word-fall-through valid/ready stream
module sdram2fifo #(
    parameter int DEPTH     = 1024,
    parameter int AW        = 10,
    parameter int BURST_LEN = 256
) (
    input  logic          clk_133M_i,
    input  logic          rst_133i,
    input  logic          clear_rdsdram_fifo,
    input  logic          rd_en_i,
    output logic          rd_req_o,
    input  logic          rd_ack_i,
    input  logic [4:0]    work_st,
    input  logic [15:0]   rd_sdram_data,
    output logic [15:0]   disp_data,
    output logic          disp_valid,
    input  logic          disp_ready,
    output logic [AW:0]   fifo_used_o,
    output logic          overflow_o
);
    localparam logic [4:0] W_RDDAT = 5'd6;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_BEAT = (AW+1)'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, REQ, RECV} state_t;
    state_t state;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   beat_cnt, ram_words;
    logic          recv, beat, full, wr, pop, load, room;

    assign recv      = state == RECV;
    assign beat      = recv && work_st == W_RDDAT;
    assign full      = fifo_used_o == DEPTH_W;
    assign wr        = beat && !full;
    assign pop       = disp_valid && disp_ready;
    // the output register counts as stored, so the RAM holds one fewer word while it is valid
    assign ram_words = fifo_used_o - {{AW{1'b0}}, disp_valid};
    assign load      = ram_words != '0 && (!disp_valid || pop);
    assign room      = DEPTH_W - fifo_used_o >= (AW+1)'(BURST_LEN);

    always_ff @(posedge clk_133M_i)
        if (wr) mem[wr_ptr] <= rd_sdram_data;

    always_ff @(posedge clk_133M_i) begin
        if (rst_133i || clear_rdsdram_fifo) begin
            state       <= IDLE;
            rd_req_o    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_used_o <= '0;
            disp_valid  <= 1'b0;
            disp_data   <= '0;
            beat_cnt    <= '0;
        end else begin
            wr_ptr      <= wr_ptr + AW'(wr);
            rd_ptr      <= rd_ptr + AW'(load);
            fifo_used_o <= fifo_used_o + (AW+1)'(wr) - (AW+1)'(pop);
            disp_valid  <= load || (disp_valid && !pop);
            if (load) disp_data <= mem[rd_ptr];
            case (state)
                IDLE: if (rd_en_i && room) begin
                    state    <= REQ;
                    rd_req_o <= 1'b1;
                end
                REQ: if (rd_ack_i) begin
                    state    <= RECV;
                    rd_req_o <= 1'b0;
                    beat_cnt <= '0;
                end
                RECV: if (beat) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (beat_cnt == LAST_BEAT) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_133M_i)
        if (rst_133i) overflow_o <= 1'b0;
        else if (beat && full) overflow_o <= 1'b1;
endmodule
